knn_uram_1r1w_be_pipe: RTL

- Parametrised successor to the kernel-local URAM 1R1W buffer.
- Adds:
  - an independent write port with byte enables;
  - a configurable read-latency pipeline with a valid flag;
  - write-to-read forwarding on same-cycle address collision;
  - out-of-range protection;
  - a self-timed clear engine for zeroing between kNN query batches.
- Sits between the partialKnn compute stage and its local search-point storage.

---
 rtl/knn_uram_1r1w_be_pipe_if.sv | 28 ++
 rtl/knn_uram_1r1w_be_pipe.sv | 105 ++++++++++
 2 files changed

// File: rtl/knn_uram_1r1w_be_pipe_if.sv
// Request/response bundle for the kNN URAM buffer: write port, read port and clear control.
// The master drives requests and the slave (the buffer) returns read data and clear status.
interface knn_uram_1r1w_be_pipe_if #(
   parameter int DataWidth    = 256,
   parameter int AddressWidth = 11,
   parameter int ByteEnWidth  = DataWidth / 8
);
   logic                    wr_en;
   logic [AddressWidth-1:0] wr_addr;
   logic [DataWidth-1:0]    wr_data;
   logic [ByteEnWidth-1:0]  wr_be;
   logic                    rd_en;
   logic [AddressWidth-1:0] rd_addr;
   logic [DataWidth-1:0]    rd_data;
   logic                    rd_valid;
   logic                    clr_start;
   logic                    clr_busy;

   modport master (
      output wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr_start,
      input  rd_data, rd_valid, clr_busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_be, rd_en, rd_addr, clr_start,
      output rd_data, rd_valid, clr_busy
   );
endinterface

// File: rtl/knn_uram_1r1w_be_pipe.sv
// Local search-point store for partialKnn: byte-enabled write port, pipelined read port with
// write-first forwarding, out-of-range protection and a self-timed zero-fill engine.
module knn_uram_1r1w_be_pipe #(
   parameter int DataWidth    = 256,
   parameter int AddressRange = 2048,
   parameter int AddressWidth = 11,
   parameter int ReadLatency  = 2,
   parameter int ByteEnWidth  = DataWidth / 8
) (
   input logic clk,
   input logic reset,
   knn_uram_1r1w_be_pipe_if.slave bus
);
   localparam int IdxWidth = $clog2(AddressRange);
   localparam logic [AddressWidth:0] Range   = (AddressWidth + 1)'(AddressRange);
   localparam logic [IdxWidth-1:0]   LastIdx = IdxWidth'(AddressRange - 1);

   typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   (* ram_style = "ultra" *) logic [DataWidth-1:0] mem [AddressRange];

   state_t                                 state, state_nxt;
   logic [IdxWidth-1:0]                    cnt, cnt_nxt;
   logic                                   clr_busy;
   logic                                   wr_acc, rd_acc, rd_inr, collide;
   logic [IdxWidth-1:0]                    widx, ridx;
   logic [DataWidth-1:0]                   rd_word;
   logic [ReadLatency-1:0]                 vld_pipe;
   logic [ReadLatency-1:0][DataWidth-1:0]  dpipe;

   assign widx    = bus.wr_addr[IdxWidth-1:0];
   assign ridx    = bus.rd_addr[IdxWidth-1:0];
   assign rd_inr  = {1'b0, bus.rd_addr} < Range;
   assign wr_acc  = bus.wr_en && !clr_busy && ({1'b0, bus.wr_addr} < Range);
   assign rd_acc  = bus.rd_en && !clr_busy;
   assign collide = wr_acc && rd_acc && (bus.wr_addr == bus.rd_addr);

   // clear engine: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // clear engine: next state
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: if (bus.clr_start) begin
            state_nxt = CLEAR;
            cnt_nxt   = '0;
         end
         CLEAR: begin
            cnt_nxt = cnt + IdxWidth'(1);
            if (cnt == LastIdx) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // clear engine: outputs
   always_comb begin
      clr_busy = (state == CLEAR);
   end

   // Write-first: an accepted write to the same address overrides its enabled bytes.
   always_comb begin
      rd_word = rd_inr ? mem[ridx] : '0;
      for (int i = 0; i < ByteEnWidth; i++)
         if (collide && bus.wr_be[i]) rd_word[8*i +: 8] = bus.wr_data[8*i +: 8];
   end

   // A reset landing mid-clear must not zero one more word.
   always_ff @(posedge clk) begin
      if (clr_busy && !reset)
         mem[cnt] <= '0;
      else if (wr_acc)
         for (int i = 0; i < ByteEnWidth; i++)
            if (bus.wr_be[i]) mem[widx][8*i +: 8] <= bus.wr_data[8*i +: 8];
   end

   // Stages only load on a valid entry, so the last stage holds the previous result.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_pipe <= '0;
         dpipe    <= '0;
      end else begin
         vld_pipe[0] <= rd_acc;
         if (rd_acc) dpipe[0] <= rd_word;
         for (int k = 1; k < ReadLatency; k++) begin
            vld_pipe[k] <= vld_pipe[k-1];
            if (vld_pipe[k-1]) dpipe[k] <= dpipe[k-1];
         end
      end
   end

   assign bus.rd_valid = vld_pipe[ReadLatency-1];
   assign bus.rd_data  = dpipe[ReadLatency-1];
   assign bus.clr_busy = clr_busy;
endmodule
